hs_response_checker: RTL and testbench
======================================

// Module: hs_response_checker
// PURPOSE
//  Sequential self-checking monitor for the half-subtractor datapath. It is the
//  receiving end of a stimulus generator: it samples applied operands a, b and the
//  DUT outputs (difference, borrow) on in_valid, compares them with the golden
//  model, counts errors, tracks input coverage and reports a pass/fail verdict.
//  It sits beside the DUT in a bench or in BIST logic.
// PARAMETERS
//  NUM_SAMPLES  4   valid samples per run before DONE (1..2**CNT_W-1)
//  CNT_W        8   width of sample/error counters
//  TIMEOUT      16  max cycles in RUN with no in_valid before forced DONE (>=1)
// PORTS
//  clk            in   1      clock, all logic on rising edge
//  rst            in   1      synchronous, active-high reset
//  start          in   1      begin a run (accepted in IDLE or DONE only)
//  in_valid       in   1      a/b/diff_in/borrow_in valid this cycle
//  a              in   1      minuend applied to DUT
//  b              in   1      subtrahend applied to DUT
//  diff_in        in   1      DUT difference output
//  borrow_in      in   1      DUT borrow output
//  busy           out  1      1 while in RUN
//  done           out  1      1 while in DONE (level, held until start/rst)
//  pass           out  1      verdict, meaningful only when done=1
//  timed_out      out  1      run ended by TIMEOUT
//  sample_count   out  CNT_W  valid samples accepted this run
//  err_count      out  CNT_W  mismatching samples this run (saturates at all-ones)
//  cov_mask       out  4      bit {a,b} set when that input pair was seen
//  first_err_idx  out  CNT_W  sample_count value at first mismatch
//  first_err_vec  out  4      {a,b,diff_in,borrow_in} of first mismatch
// BEHAVIOUR
//  - Golden model: exp_diff = a ^ b; exp_borrow = ~a & b. Mismatch if either differs.
//  - FSM states IDLE, RUN, DONE. Reset -> IDLE; all outputs 0.
//  - IDLE/DONE + start: next edge -> RUN; counters, cov_mask, first_err_*, timed_out,
//    pass cleared on that edge. in_valid in the same cycle as start is ignored.
//  - RUN + in_valid: sample accepted on that edge; sample_count+1, cov_mask|=bit,
//    err_count+1 on mismatch (saturating), first_err_* captured on first mismatch only
//    (first_err_idx = sample_count before increment). Results visible next cycle.
//  - RUN: idle counter clears on every accepted sample, else increments; when it
//    reaches TIMEOUT -> DONE with timed_out=1.
//  - Accepted sample that makes sample_count == NUM_SAMPLES -> DONE on same edge;
//    done=1 the following cycle (1-cycle latency from last valid).
//  - Last sample and timeout on same edge: sample wins, timed_out=0.
//  - pass = (err_count==0) && (cov_mask==4'hF) && !timed_out, registered on DONE entry.
//  - start in RUN ignored; in_valid in IDLE/DONE ignored; sample_count never wraps.
//  - rst mid-run: IDLE and full clear on that edge, run discarded.
// TESTING
//  1. Good DUT, vectors 00,01,10,11 (diff/borrow 00,11,10,00) -> done, pass=1,
//     err_count=0, cov_mask=F, sample_count=4.
//  2. Sample 2 (a=1,b=0) with borrow_in=1 -> err_count=1, first_err_idx=2,
//     first_err_vec=4'b1011, pass=0.
//  3. Four samples all 11 correct -> cov_mask=4'b1000, err_count=0, pass=0.
//  4. Start, 2 samples, then no in_valid for 16 cycles -> done, timed_out=1,
//     sample_count=2, pass=0.
//  5. rst after 2 samples -> next cycle busy=0, sample_count=0, cov_mask=0; restart
//     and full good run -> pass=1.
//  6. start held during RUN and in_valid in IDLE -> no restart, no counting.

Source files
------------

// File: rtl/hs_response_checker.sv
// hs_response_checker: compares half-subtractor outputs to a golden model, tracks coverage and issues a verdict
module hs_response_checker #(
    parameter int NUM_SAMPLES = 4,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    input  logic             diff_in,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timed_out,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [3:0]       cov_mask,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [3:0]       first_err_vec
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int IW = $clog2(TIMEOUT + 1);
    state_t state, state_nx;
    logic [IW-1:0] idle_cnt;
    logic launch, accept, mism, last, expire;
    logic [CNT_W-1:0] err_nx;
    logic [3:0] cov_nx;
    assign launch = (state != RUN) && start;
    assign accept = (state == RUN) && in_valid;
    assign mism   = (diff_in != (a ^ b)) || (borrow_in != (~a & b));
    assign last   = accept && (sample_count == CNT_W'(NUM_SAMPLES - 1));
    assign expire = (state == RUN) && !in_valid && (idle_cnt == IW'(TIMEOUT - 1));
    assign err_nx = (accept && mism && !(&err_count)) ? err_count + CNT_W'(1) : err_count;
    assign cov_nx = accept ? (cov_mask | (4'b0001 << {a, b})) : cov_mask;
    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    // Next state: start launches a run from IDLE/DONE; last sample or idle timeout ends it
    always_comb begin
        state_nx = state;
        state_nx = launch ? RUN : (last || expire) ? DONE : state;
    end
    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // Run bookkeeping: counters, coverage, first-error capture and verdict latch
    always_ff @(posedge clk) begin
        if (rst || launch) begin
            idle_cnt      <= '0;
            sample_count  <= '0;
            err_count     <= '0;
            cov_mask      <= '0;
            first_err_idx <= '0;
            first_err_vec <= '0;
            timed_out     <= 1'b0;
            pass          <= 1'b0;
        end else if (state == RUN) begin
            idle_cnt <= accept ? '0 : idle_cnt + IW'(1);
            if (accept) begin
                sample_count <= sample_count + CNT_W'(1);
                err_count    <= err_nx;
                cov_mask     <= cov_nx;
                if (mism && err_count == '0) begin
                    first_err_idx <= sample_count;
                    first_err_vec <= {a, b, diff_in, borrow_in};
                end
            end
            if (expire) timed_out <= 1'b1;
            if (last || expire) pass <= (err_nx == '0) && (cov_nx == 4'hF) && !expire;
        end
    end
endmodule

// File: tb/tb_hs_response_checker.sv
// tb_hs_response_checker: directed and randomized checks against a sample-list reference model
module tb_hs_response_checker;
    localparam int N = 4, W = 8, TO = 16;
    logic clk = 0, rst = 1, start = 0, in_valid = 0, a = 0, b = 0, diff_in = 0, borrow_in = 0;
    logic busy, done, pass, timed_out;
    logic [W-1:0] sample_count, err_count, first_err_idx;
    logic [3:0] cov_mask, first_err_vec;
    int tests = 0, fails = 0;
    int ph = 0, idle = 0;
    bit mto = 0, mpass = 0;
    logic [3:0] q[$];

    always #5 clk = ~clk;

    hs_response_checker #(.NUM_SAMPLES(N), .CNT_W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .a(a), .b(b),
        .diff_in(diff_in), .borrow_in(borrow_in), .busy(busy), .done(done), .pass(pass),
        .timed_out(timed_out), .sample_count(sample_count), .err_count(err_count),
        .cov_mask(cov_mask), .first_err_idx(first_err_idx), .first_err_vec(first_err_vec)
    );

    function automatic bit bad_vec(logic [3:0] v);
        return (v[1] != (v[3] ^ v[2])) || (v[0] != (!v[3] && v[2]));
    endfunction

    function automatic int m_err();
        int e = 0;
        foreach (q[i]) if (bad_vec(q[i])) e++;
        return (e > 2**W - 1) ? 2**W - 1 : e;
    endfunction

    function automatic logic [3:0] m_cov();
        logic [3:0] c = 0;
        foreach (q[i]) c[q[i][3:2]] = 1'b1;
        return c;
    endfunction

    function automatic int m_first_idx();
        foreach (q[i]) if (bad_vec(q[i])) return i;
        return 0;
    endfunction

    function automatic logic [3:0] m_first_vec();
        foreach (q[i]) if (bad_vec(q[i])) return q[i];
        return 4'h0;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic model();
        if (rst) begin
            ph = 0; q.delete(); mto = 0; idle = 0; mpass = 0;
        end else if (ph != 1) begin
            if (start) begin
                ph = 1; q.delete(); mto = 0; idle = 0; mpass = 0;
            end
        end else if (in_valid) begin
            q.push_back({a, b, diff_in, borrow_in});
            idle = 0;
            if (q.size() == N) begin
                ph = 2;
                mpass = (m_err() == 0) && (m_cov() == 4'hF);
            end
        end else begin
            idle++;
            if (idle == TO) begin
                ph = 2; mto = 1; mpass = 0;
            end
        end
    endtask

    task automatic compare();
        chk("busy", 32'(busy), 32'(ph == 1));
        chk("done", 32'(done), 32'(ph == 2));
        chk("timed_out", 32'(timed_out), 32'(mto));
        chk("pass", 32'(pass), 32'(mpass));
        chk("sample_count", 32'(sample_count), 32'(q.size()));
        chk("err_count", 32'(err_count), 32'(m_err()));
        chk("cov_mask", 32'(cov_mask), 32'(m_cov()));
        chk("first_err_idx", 32'(first_err_idx), 32'(m_first_idx()));
        chk("first_err_vec", 32'(first_err_vec), 32'(m_first_vec()));
    endtask

    task automatic drive(input bit r, input bit s, input bit v, input bit ia, input bit ib,
                         input bit ed, input bit eb);
        rst = r; start = s; in_valid = v; a = ia; b = ib;
        diff_in = (ia ^ ib) ^ ed;
        borrow_in = (!ia && ib) ^ eb;
        @(posedge clk);
        model();
        @(negedge clk);
        compare();
    endtask

    task automatic good_run();
        drive(0, 1, 1, 1, 1, 1, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, i[1], i[0], 0, 0);
    endtask

    initial begin
        bit dense;
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_count", 32'(sample_count), 0);
        good_run();
        chk("t1_done", 32'(done), 1);
        chk("t1_pass", 32'(pass), 1);
        chk("t1_err", 32'(err_count), 0);
        chk("t1_cov", 32'(cov_mask), 32'hF);
        chk("t1_count", 32'(sample_count), 4);
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 1, 0, 0);
        drive(0, 0, 1, 1, 0, 0, 1);
        drive(0, 0, 1, 1, 1, 0, 0);
        chk("t2_done", 32'(done), 1);
        chk("t2_err", 32'(err_count), 1);
        chk("t2_idx", 32'(first_err_idx), 2);
        chk("t2_vec", 32'(first_err_vec), 32'hB);
        chk("t2_pass", 32'(pass), 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 1, 1, 0, 0);
        chk("t3_cov", 32'(cov_mask), 32'h8);
        chk("t3_err", 32'(err_count), 0);
        chk("t3_pass", 32'(pass), 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 1, 0, 0);
        drive(0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 15; i++) drive(0, 0, 0, 0, 0, 0, 0);
        chk("t4_not_yet", 32'(done), 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("t4_done", 32'(done), 1);
        chk("t4_to", 32'(timed_out), 1);
        chk("t4_count", 32'(sample_count), 2);
        chk("t4_pass", 32'(pass), 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 1, 0, 0);
        drive(1, 0, 1, 1, 0, 0, 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_count", 32'(sample_count), 0);
        chk("t5_cov", 32'(cov_mask), 0);
        good_run();
        chk("t5_pass", 32'(pass), 1);
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 0, 0, 0);
        chk("t6_idle_count", 32'(sample_count), 0);
        chk("t6_idle_busy", 32'(busy), 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 1, 1, i[1], i[0], 0, 0);
        chk("t6_count", 32'(sample_count), 4);
        chk("t6_done", 32'(done), 1);
        dense = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 40 == 0) dense = 1'($urandom_range(0, 1));
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
                  dense ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0),
                  1'($urandom), 1'($urandom),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
